bbq_key_decoder: RTL

BBQ_KEY_DECODER -- requirements
Module: bbq_key_decoder

---
 rtl/bbq_key_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bbq_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bbq_key_decoder
// Description : Maps decoded PS/2 make/break events and active-low push
//               buttons onto NUM_CH logical key channels. Each channel can
//               follow the key (hold mode) or flip on each fresh press
//               (toggle mode). Each channel also reports edge pulses and how
//               long it has been held, in prescaler ticks.
// Ports       : clk, resetn          - clock, async active-low reset
//               valid/makeBreak/outCode - decoded PS/2 event (strobe, 1=make)
//               key_n[NUM_CH]        - async active-low buttons
//               clear                - drop all keyboard-derived state
//               pressed/press_pulse/release_pulse[NUM_CH] - level and edges
//               hold_ms[NUM_CH*HOLD_W] - per-channel hold tick counters
//               any_pressed          - OR of all pressed bits
// Revision    : 1.0 - initial release
// ============================================================================
module bbq_key_decoder #(
  parameter int                  NUM_CH      = 6,
  parameter logic [8*NUM_CH-1:0] CODES       = {8'h7A, 8'h72, 8'h69, 8'h74, 8'h73, 8'h6B},
  parameter int                  TOGGLE_MODE = 0,
  parameter int                  HOLD_W      = 16,
  parameter int                  TICK_DIV    = 50000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     valid,
  input  logic                     makeBreak,
  input  logic [7:0]               outCode,
  input  logic [NUM_CH-1:0]        key_n,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        pressed,
  output logic [NUM_CH-1:0]        press_pulse,
  output logic [NUM_CH-1:0]        release_pulse,
  output logic [NUM_CH*HOLD_W-1:0] hold_ms,
  output logic                     any_pressed
);

  localparam int                 c_pre_w   = $clog2(TICK_DIV);
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(TICK_DIV - 1);

  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;
  logic [NUM_CH-1:0]  w_match;
  logic [NUM_CH-1:0]  r_kb_held;
  logic [NUM_CH-1:0]  r_kb_raw;
  logic [NUM_CH-1:0]  r_kb_latch;
  logic [NUM_CH-1:0]  w_kb_state;
  logic [NUM_CH-1:0]  r_sync1;
  logic [NUM_CH-1:0]  r_sync2;
  logic [NUM_CH-1:0]  w_btn;
  logic [NUM_CH-1:0]  w_pressed_next;
  logic [NUM_CH-1:0]  r_pressed;
  logic [NUM_CH-1:0]  r_press_pulse;
  logic [NUM_CH-1:0]  r_release_pulse;
  logic               r_any;

  // Free-running prescaler; the tick is the cycle in which it wraps.
  assign w_tick = (r_pre == c_pre_max);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + c_pre_w'(1);
    end
  end

  // Keyboard state. Both hold and toggle state are kept; the mode only
  // selects which one feeds pressed. r_kb_raw remembers whether the key is
  // physically down so typematic repeats do not re-toggle the latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_kb_held  <= '0;
      r_kb_raw   <= '0;
      r_kb_latch <= '0;
    end else if (clear) begin
      r_kb_held  <= '0;
      r_kb_raw   <= '0;
      r_kb_latch <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_match[i]) begin
          r_kb_held[i] <= makeBreak;
          r_kb_raw[i]  <= makeBreak;
          if (makeBreak && !r_kb_raw[i]) begin
            r_kb_latch[i] <= ~r_kb_latch[i];
          end
        end
      end
    end
  end

  assign w_kb_state = (TOGGLE_MODE != 0) ? r_kb_latch : r_kb_held;

  // The synchronizer carries the inverted (active-high) button level so its
  // reset value of 0 is the released state and reset exit is pulse-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn          = r_sync2;
  assign w_pressed_next = w_kb_state | w_btn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pressed       <= '0;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
      r_any           <= 1'b0;
    end else begin
      r_pressed       <= w_pressed_next;
      r_press_pulse   <= w_pressed_next & ~r_pressed;
      r_release_pulse <= ~w_pressed_next & r_pressed;
      r_any           <= |w_pressed_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [HOLD_W-1:0] r_hold;

    assign w_match[gi] = valid && (outCode == CODES[8*gi +: 8]);

    // Reload during the press pulse, then count ticks while pressed and
    // stick at all-ones. After release the last value is kept.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_hold <= '0;
      end else if (r_press_pulse[gi]) begin
        r_hold <= '0;
      end else if (w_tick && r_pressed[gi] && (r_hold != {HOLD_W{1'b1}})) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end

    assign hold_ms[HOLD_W*gi +: HOLD_W] = r_hold;
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign any_pressed   = r_any;

endmodule
`default_nettype wire
